mmio_gpio_hub: RTL and testbench

//  Parametrised memory-mapped GPIO block for the single-cycle CPU IO path; supersedes the separate led/switch blocks.

---
 rtl/mmio_gpio_hub.sv | 94 +++++++++
 tb/tb_mmio_gpio_hub.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_gpio_hub.sv
// mmio_gpio_hub: memory-mapped LED/switch GPIO with a one-shot submit event and sticky clear-on-read status.
// Define GPIO_DEBOUNCE_EN to condition the submit button through a debounce counter.
module mmio_gpio_hub #(
  parameter int LED_W = 24,
  parameter int SW_W = 24,
  parameter int SNAPSHOT = 0,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_read,
  input  logic             io_write,
  input  logic             led_ctrl,
  input  logic             switch_ctrl,
  input  logic [3:0]       addr,
  input  logic [15:0]      write_data,
  output logic [15:0]      read_data,
  input  logic [SW_W-1:0]  switches,
  input  logic             submit,
  output logic [LED_W-1:0] leds,
  output logic             submit_pending
);
  localparam int LED_BANKS = (LED_W + 15) / 16;
  localparam int SW_BANKS = (SW_W + 15) / 16;
  localparam logic [3:0] LB = 4'(LED_BANKS);
  localparam logic [3:0] SB = 4'(SW_BANKS);
  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [2:0] idx;
  logic led_hit, sw_hit, led_wr, status_rd;
  logic [LED_W-1:0] leds_n;
  logic [63:0] led_pad, sw_pad;
  logic [SW_W-1:0] sw_s1, sw_s2, snap;
  logic sub_s1, sub_s2, stable, stable_q, sub_event;
  logic unused_ok;
  assign idx = addr[3:1];
  assign led_hit = {1'b0, idx} < LB;
  assign sw_hit = idx[2] && ({2'b0, idx[1:0]} < SB);
  assign led_wr = io_write && led_ctrl && led_hit;
  assign status_rd = io_read && led_ctrl && idx == 3'd7;
  assign sub_event = stable && !stable_q;
  assign unused_ok = addr[0] ^ DB_MAX[0];
  always_comb begin
    led_pad = '0;
    led_pad[LED_W-1:0] = leds;
    sw_pad = '0;
    sw_pad[SW_W-1:0] = SNAPSHOT != 0 ? snap : sw_s2;
    for (int i = 0; i < LED_W; i++)
      leds_n[i] = (led_wr && idx[1:0] == 2'(i / 16)) ? write_data[i % 16] : leds[i];
  end
  assign read_data = !io_read                 ? 16'h0000 :
                     (led_ctrl && led_hit)    ? led_pad[{idx[1:0], 4'b0000} +: 16] :
                     status_rd                ? {15'b0, submit_pending} :
                     (switch_ctrl && sw_hit)  ? sw_pad[{idx[1:0], 4'b0000} +: 16] :
                                                16'h0000;
  // Event and status read in the same cycle: the event wins so it is never lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      leds <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      snap <= '0;
      sub_s1 <= 1'b0;
      sub_s2 <= 1'b0;
      stable_q <= 1'b0;
      submit_pending <= 1'b0;
    end else begin
      leds <= leds_n;
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
      sub_s1 <= submit;
      sub_s2 <= sub_s1;
      stable_q <= stable;
      submit_pending <= sub_event || (submit_pending && !status_rd);
      if (sub_event) snap <= sw_s2;
    end
  end
`ifdef GPIO_DEBOUNCE_EN
  logic [15:0] db_cnt;
  // The level is accepted only after it differs from stable for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (sub_s2 != stable) begin
      db_cnt <= db_cnt == DB_MAX ? 16'd0 : db_cnt + 16'd1;
      if (db_cnt == DB_MAX) stable <= ~stable;
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign stable = sub_s2;
`endif
endmodule

// File: tb/tb_mmio_gpio_hub.sv
// tb_mmio_gpio_hub: directed checks of LED/switch mapping, submit event, status and snapshot.
module tb_mmio_gpio_hub;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int EV = DB + 2;
`else
  localparam int EV = 2;
`endif
  logic clock = 1'b0, reset = 1'b0;
  logic io_read = 1'b0, io_write = 1'b0, led_ctrl = 1'b0, switch_ctrl = 1'b0;
  logic [3:0] addr = '0;
  logic [15:0] write_data = '0;
  logic [23:0] switches = '0;
  logic submit = 1'b0;
  logic [15:0] rd0, rd1, d0, d1;
  logic [23:0] leds0, leds1;
  logic pend0, pend1;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  mmio_gpio_hub #(.LED_W(24), .SW_W(24), .SNAPSHOT(0), .DEBOUNCE_CYCLES(DB)) dut0 (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .led_ctrl(led_ctrl), .switch_ctrl(switch_ctrl), .addr(addr), .write_data(write_data),
    .read_data(rd0), .switches(switches), .submit(submit), .leds(leds0), .submit_pending(pend0));
  mmio_gpio_hub #(.LED_W(24), .SW_W(24), .SNAPSHOT(1), .DEBOUNCE_CYCLES(DB)) dut1 (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .led_ctrl(led_ctrl), .switch_ctrl(switch_ctrl), .addr(addr), .write_data(write_data),
    .read_data(rd1), .switches(switches), .submit(submit), .leds(leds1), .submit_pending(pend1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wr(input logic lc, input logic sc, input logic [2:0] i, input logic [15:0] d);
    io_write = 1'b1;
    led_ctrl = lc;
    switch_ctrl = sc;
    addr = {i, 1'b0};
    write_data = d;
    tick();
    io_write = 1'b0;
    led_ctrl = 1'b0;
    switch_ctrl = 1'b0;
  endtask
  task automatic rd(input logic lc, input logic sc, input logic [2:0] i, input logic through_edge);
    io_read = 1'b1;
    led_ctrl = lc;
    switch_ctrl = sc;
    addr = {i, 1'b1};
    #1;
    d0 = rd0;
    d1 = rd1;
    if (through_edge) tick();
    io_read = 1'b0;
    led_ctrl = 1'b0;
    switch_ctrl = 1'b0;
  endtask
  initial begin
    tick(3);
    reset = 1'b1;
    check("rst_leds", leds0, 24'h0);
    check("rst_pend", pend0, 0);
    rd(1, 0, 0, 0);
    check("rst_rd_idx0", d0, 16'h0);
    wr(1, 0, 0, 16'hBEEF);
    wr(1, 0, 1, 16'h00A5);
    check("leds_a5beef", leds0, 24'hA5BEEF);
    rd(1, 0, 1, 0);
    check("rd_idx1", d0, 16'h00A5);
    rd(1, 0, 0, 0);
    check("rd_idx0", d0, 16'hBEEF);
    wr(1, 0, 3, 16'hFFFF);
    wr(1, 0, 2, 16'hFFFF);
    wr(0, 1, 0, 16'h1111);
    check("ignored_writes", leds0, 24'hA5BEEF);
    wr(1, 0, 1, 16'hFFFF);
    check("leds_trunc", leds0, 24'hFFBEEF);
    rd(1, 0, 1, 0);
    check("rd_idx1_trunc", d0, 16'h00FF);
    io_read = 1'b0;
    led_ctrl = 1'b1;
    addr = 4'h0;
    #1;
    check("no_strobe_zero", rd0, 16'h0);
    led_ctrl = 1'b0;
    switches = 24'h5A1234;
    rd(0, 1, 4, 0);
    check("sw_edge0", d0, 16'h0);
    tick();
    rd(0, 1, 4, 0);
    check("sw_edge1", d0, 16'h0);
    tick();
    rd(0, 1, 4, 0);
    check("sw_idx4", d0, 16'h1234);
    rd(0, 1, 5, 0);
    check("sw_idx5", d0, 16'h005A);
    rd(0, 1, 6, 0);
    check("sw_idx6", d0, 16'h0);
    rd(1, 0, 4, 0);
    check("sw_wrong_ctrl", d0, 16'h0);
    rd(0, 1, 0, 0);
    check("sw_ctrl_led_idx", d0, 16'h0);
    // Glitching press then a long hold.
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    submit = 1'b1;
    tick(10);
    check("glitch_pend", pend0, 1);
    rd(1, 0, 7, 1);
    check("status_1", d0, 16'h0001);
    rd(1, 0, 7, 1);
    check("status_0", d0, 16'h0000);
    tick(5);
    check("held_no_event", pend0, 0);
    rd(0, 1, 4, 0);
    check("snap_first", d1, 16'h1234);
    submit = 1'b0;
    tick(10);
    check("release_no_event", pend0, 0);
    // Event coincides with a status read.
    submit = 1'b1;
    tick(EV - 1);
    check("pre_event_pend", pend0, 0);
    tick();
    rd(1, 0, 7, 1);
    check("same_cycle_rd", d0, 16'h0000);
    check("same_cycle_pend", pend0, 1);
    rd(1, 0, 7, 1);
    submit = 1'b0;
    tick(10);
    // Snapshot holds the switches seen at the submit event.
    switches = 24'h000011;
    tick(3);
    submit = 1'b1;
    tick(10);
    submit = 1'b0;
    tick(10);
    switches = 24'h000022;
    tick(3);
    rd(0, 1, 4, 0);
    check("snap_holds", d1, 16'h0011);
    check("live_follows", d0, 16'h0022);
    submit = 1'b1;
    tick(10);
    submit = 1'b0;
    tick(10);
    rd(0, 1, 4, 0);
    check("snap_updates", d1, 16'h0022);
    rd(1, 0, 7, 1);
    check("snap_status", d0, 16'h0001);
    // Reset in the middle of a press.
    wr(1, 0, 3, 16'h1234);
    check("idx3_ignored", leds0, 24'hFFBEEF);
    submit = 1'b1;
    tick(2);
    reset = 1'b0;
    submit = 1'b0;
    tick(2);
    reset = 1'b1;
    check("midpress_leds", leds0, 24'h0);
    check("midpress_pend", pend0, 0);
    tick(10);
    check("midpress_no_event", pend0, 0);
    submit = 1'b1;
    tick(10);
    check("repress_event", pend0, 1);
    check("repress_event_snap", pend1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
